// File: rtl/gibbs_sweep_ctrl.sv
// Gibbs sweep sequencer: owns the packed node-colour state, walks node/bit addresses
// for the update datapath and runs N sweeps. Optional abort input via GIBBS_SWEEP_ABORT_EN.
//
// state    | meaning
// S_IDLE   | waiting for start; load_init may overwrite nodes
// S_BIT    | address held UPD_LATENCY+1 cycles, new_val sampled on the last one
// S_COMMIT | write clamped shadow colour into the current node slot
// S_FINISH | one-cycle done pulse, back to idle
module gibbs_sweep_ctrl #(
  parameter int NUM_NODES       = 4,
  parameter int NUM_NODES_BIT   = 2,
  parameter int NUM_COLORS      = 4,
  parameter int NUM_COLORS_BITS = 2,
  parameter int UPD_LATENCY     = 0,
  parameter int SWEEP_BITS      = 16,
  localparam int CB_W = (NUM_COLORS_BITS > 1) ? $clog2(NUM_COLORS_BITS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [SWEEP_BITS-1:0]                num_sweeps,
  input  logic                                 load_init,
  input  logic [NUM_NODES*NUM_COLORS_BITS-1:0] init_nodes,
  input  logic                                 new_val,
`ifdef GIBBS_SWEEP_ABORT_EN
  input  logic                                 abort,
`endif
  output logic [NUM_NODES_BIT-1:0]             node_count,
  output logic [CB_W-1:0]                      color_bit_count,
  output logic [NUM_NODES*NUM_COLORS_BITS-1:0] nodes,
  output logic                                 busy,
  output logic                                 done,
  output logic [SWEEP_BITS-1:0]                sweep_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BIT    = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int WAIT_W = (UPD_LATENCY > 0) ? $clog2(UPD_LATENCY + 1) : 1;
  localparam logic [WAIT_W-1:0]          WAIT_LOAD = WAIT_W'(UPD_LATENCY);
  localparam logic [CB_W-1:0]            LAST_BIT  = CB_W'(NUM_COLORS_BITS - 1);
  localparam logic [NUM_NODES_BIT-1:0]   LAST_NODE = NUM_NODES_BIT'(NUM_NODES - 1);
  localparam logic [NUM_COLORS_BITS-1:0] COLOR_MAX = NUM_COLORS_BITS'(NUM_COLORS - 1);

  logic [1:0]                 state;
  logic [NUM_COLORS_BITS-1:0] shadow;
  logic [NUM_COLORS_BITS-1:0] commit_val;
  logic [WAIT_W-1:0]          wait_cnt;
  logic [SWEEP_BITS-1:0]      sweeps_q;
  logic [SWEEP_BITS-1:0]      sweep_next;
  logic                       abort_req;

`ifdef GIBBS_SWEEP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    commit_val = shadow;
    if (int'(shadow) >= NUM_COLORS) commit_val = COLOR_MAX;
    sweep_next = sweep_count + SWEEP_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      nodes           <= '0;
      node_count      <= '0;
      color_bit_count <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      sweep_count     <= '0;
      sweeps_q        <= '0;
      shadow          <= '0;
      wait_cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_init) nodes <= init_nodes;
          if (start) begin
            sweeps_q        <= num_sweeps;
            sweep_count     <= '0;
            node_count      <= '0;
            color_bit_count <= '0;
            shadow          <= '0;
            wait_cnt        <= WAIT_LOAD;
            if (num_sweeps == '0) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state <= S_BIT;
              busy  <= 1'b1;
            end
          end
        end
        S_BIT: begin
          if (abort_req) begin
            state  <= S_FINISH;
            busy   <= 1'b0;
            done   <= 1'b1;
            shadow <= '0;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else begin
            shadow[color_bit_count] <= new_val;
            wait_cnt                <= WAIT_LOAD;
            if (color_bit_count == LAST_BIT) state <= S_COMMIT;
            else color_bit_count <= color_bit_count + CB_W'(1);
          end
        end
        S_COMMIT: begin
          if (abort_req) begin
            state  <= S_FINISH;
            busy   <= 1'b0;
            done   <= 1'b1;
            shadow <= '0;
          end else begin
            // whole-colour write keeps every bit of a node computed against its old colour
            nodes[node_count*NUM_COLORS_BITS +: NUM_COLORS_BITS] <= commit_val;
            shadow          <= '0;
            color_bit_count <= '0;
            if (node_count != LAST_NODE) begin
              node_count <= node_count + NUM_NODES_BIT'(1);
              state      <= S_BIT;
            end else begin
              node_count  <= '0;
              sweep_count <= sweep_next;
              if (sweep_next == sweeps_q) begin
                state <= S_FINISH;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= S_BIT;
              end
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gibbs_sweep_ctrl.sv
// Directed bench for gibbs_sweep_ctrl: default, NUM_COLORS=3 and UPD_LATENCY=2 instances.
module tb_gibbs_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, load_a, nv_a, busy_a, done_a;
  logic [7:0]  init_a, nodes_a;
  logic [15:0] ns_a, sc_a;
  logic [1:0]  nc_a;
  logic [0:0]  cbc_a;

  logic        start_b, load_b, nv_b, busy_b, done_b;
  logic [7:0]  init_b, nodes_b;
  logic [15:0] ns_b, sc_b;
  logic [1:0]  nc_b;
  logic [0:0]  cbc_b;

  logic        start_c, load_c, nv_c, busy_c, done_c;
  logic [7:0]  init_c, nodes_c;
  logic [15:0] ns_c, sc_c;
  logic [1:0]  nc_c;
  logic [0:0]  cbc_c;

`ifdef GIBBS_SWEEP_ABORT_EN
  logic abort_a, abort_b, abort_c;
`endif

  gibbs_sweep_ctrl u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_sweeps(ns_a), .load_init(load_a),
    .init_nodes(init_a), .new_val(nv_a),
`ifdef GIBBS_SWEEP_ABORT_EN
    .abort(abort_a),
`endif
    .node_count(nc_a), .color_bit_count(cbc_a), .nodes(nodes_a), .busy(busy_a),
    .done(done_a), .sweep_count(sc_a)
  );

  gibbs_sweep_ctrl #(.NUM_COLORS(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_sweeps(ns_b), .load_init(load_b),
    .init_nodes(init_b), .new_val(nv_b),
`ifdef GIBBS_SWEEP_ABORT_EN
    .abort(abort_b),
`endif
    .node_count(nc_b), .color_bit_count(cbc_b), .nodes(nodes_b), .busy(busy_b),
    .done(done_b), .sweep_count(sc_b)
  );

  gibbs_sweep_ctrl #(.UPD_LATENCY(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .num_sweeps(ns_c), .load_init(load_c),
    .init_nodes(init_c), .new_val(nv_c),
`ifdef GIBBS_SWEEP_ABORT_EN
    .abort(abort_c),
`endif
    .node_count(nc_c), .color_bit_count(cbc_c), .nodes(nodes_c), .busy(busy_c),
    .done(done_c), .sweep_count(sc_c)
  );

  int tests = 0;
  int fails = 0;
  int busy_cnt, done_cnt, done_at, seq_err, p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    start_a = 0; load_a = 0; nv_a = 0; init_a = 0; ns_a = 0;
    start_b = 0; load_b = 0; nv_b = 0; init_b = 0; ns_b = 0;
    start_c = 0; load_c = 0; nv_c = 0; init_c = 0; ns_c = 0;
`ifdef GIBBS_SWEEP_ABORT_EN
    abort_a = 0; abort_b = 0; abort_c = 0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // reset in idle after loading a nonzero state
    load_a = 1; init_a = 8'h5A;
    @(negedge clk);
    load_a = 0;
    check("load_idle", nodes_a, 8'h5A);
    #2 rst = 1'b0;
    #1;
    check("rst_nodes", nodes_a, 8'h00);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_sweep", sc_a, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_nodes", nodes_a, 8'h00);
    check("post_rst_busy", busy_a, 0);

    // one sweep, new_val tied 1, from E4
    load_a = 1; init_a = 8'hE4; ns_a = 16'd1; start_a = 1; nv_a = 1;
    @(negedge clk);
    load_a = 0; start_a = 0;
    busy_cnt = 0; done_cnt = 0; done_at = 0; seq_err = 0;
    for (int k = 1; k <= 14; k++) begin
      if (busy_a) busy_cnt++;
      if (done_a) begin done_cnt++; done_at = k; end
      if (k <= 12 && nc_a !== 2'((k - 1) / 3)) seq_err++;
      if (k == 2) check("t1_hold_mid_node", nodes_a, 8'hE4);
      if (k == 4) check("t1_node0_commit", nodes_a, 8'hE7);
      @(negedge clk);
    end
    check("t1_busy_cycles", busy_cnt, 12);
    check("t1_done_cycle", done_at, 13);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_node_seq_err", seq_err, 0);
    check("t1_nodes", nodes_a, 8'hFF);
    check("t1_sweep", sc_a, 1);
    check("t1_nc_idle", nc_a, 0);
    check("t1_cbc_idle", cbc_a, 0);

    // NUM_COLORS=3 clamp, two sweeps, start/load/num_sweeps poked while busy
    ns_b = 16'd2; start_b = 1; nv_b = 1;
    @(negedge clk);
    start_b = 0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 26; k++) begin
      if (busy_b) busy_cnt++;
      if (done_b) begin done_cnt++; done_at = k; end
      if (k == 4) check("t2_node0_clamp", nodes_b, 8'h02);
      if (k == 7) check("t2_node1_clamp", nodes_b, 8'h0A);
      if (k == 13) check("t2_sweep_mid", sc_b, 1);
      if (k == 5) begin
        start_b = 1; load_b = 1; init_b = 8'h00; ns_b = 16'd1;
      end else begin
        start_b = 0; load_b = 0;
      end
      @(negedge clk);
    end
    check("t2_busy_cycles", busy_cnt, 24);
    check("t2_done_cycle", done_at, 25);
    check("t2_done_pulses", done_cnt, 1);
    check("t2_nodes", nodes_b, 8'hAA);
    check("t2_sweep", sc_b, 2);

    // zero sweeps
    load_a = 1; init_a = 8'h1B; ns_a = 16'd0; start_a = 1;
    @(negedge clk);
    load_a = 0; start_a = 0;
    check("t3_done", done_a, 1);
    check("t3_busy", busy_a, 0);
    @(negedge clk);
    check("t3_done_clear", done_a, 0);
    check("t3_busy_after", busy_a, 0);
    check("t3_nodes", nodes_a, 8'h1B);
    check("t3_sweep", sc_a, 0);

    // UPD_LATENCY=2: new_val high except in each sample cycle
    load_c = 1; init_c = 8'hFF; ns_c = 16'd1; start_c = 1; nv_c = 1;
    @(negedge clk);
    load_c = 0; start_c = 0;
    busy_cnt = 0; done_cnt = 0; done_at = 0; seq_err = 0;
    for (int k = 1; k <= 30; k++) begin
      if (busy_c) busy_cnt++;
      if (done_c) begin done_cnt++; done_at = k; end
      p = (k - 1) % 7;
      if (k <= 28) begin
        if (nc_c !== 2'((k - 1) / 7)) seq_err++;
        if (cbc_c !== ((p >= 3) ? 1'b1 : 1'b0)) seq_err++;
      end
      if (k == 3) check("t4_hold_mid_node", nodes_c, 8'hFF);
      nv_c = (p == 2 || p == 5) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    check("t4_busy_cycles", busy_cnt, 28);
    check("t4_done_cycle", done_at, 29);
    check("t4_addr_seq_err", seq_err, 0);
    check("t4_nodes", nodes_c, 8'h00);

    // reset in the middle of a run, then a full run
    ns_a = 16'd1; start_a = 1; nv_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (4) @(negedge clk);
    check("t5_pre_rst_nc", nc_a, 1);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_nodes", nodes_a, 8'h00);
    check("t5_rst_nc", nc_a, 0);
    check("t5_rst_cbc", cbc_a, 0);
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_done", done_a, 0);
    check("t5_rst_sweep", sc_a, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 14; k++) begin
      if (busy_a) busy_cnt++;
      if (done_a) begin done_cnt++; done_at = k; end
      @(negedge clk);
    end
    check("t5_busy_cycles", busy_cnt, 12);
    check("t5_done_cycle", done_at, 13);
    check("t5_nodes", nodes_a, 8'hFF);
    check("t5_sweep", sc_a, 1);

`ifdef GIBBS_SWEEP_ABORT_EN
    load_a = 1; init_a = 8'hE4; ns_a = 16'd1; start_a = 1; nv_a = 1;
    @(negedge clk);
    load_a = 0; start_a = 0;
    done_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      if (done_a) done_cnt++;
      if (k == 5) begin
        check("ab_done", done_a, 1);
        check("ab_busy", busy_a, 0);
      end
      abort_a = (k == 4) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    check("ab_done_pulses", done_cnt, 1);
    check("ab_nodes", nodes_a, 8'hE7);
    check("ab_sweep", sc_a, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gibbs_sweep_ctrl.md
Name: gibbs_sweep_ctrl

Overview:
- Sequencer on the other side of the node update datapath.
- Owns the packed node-colour state register and drives it out as `nodes`.
- Walks node_count/color_bit_count over every node and colour bit, samples the returned new_val, and writes completed colours back.
- Runs a requested number of full Gibbs sweeps, with start/busy/done handshake to the host-side controller.

Parameters:
- NUM_NODES, 4, number of nodes
- NUM_NODES_BIT, 2, width of node index
- NUM_COLORS, 4, legal colours per node (values 0..NUM_COLORS-1)
- NUM_COLORS_BITS, 2, bits per node colour
- UPD_LATENCY, 0, extra cycles from address change to valid new_val
- SWEEP_BITS, 16, width of sweep counters

Ports:
- clk  input  1  machine clock
- rst  input  1  asynchronous active-low reset
- start  input  1  begin run; accepted only in IDLE
- num_sweeps  input  SWEEP_BITS  sweeps to run, latched on accepted start
- load_init  input  1  in IDLE, load init_nodes into state
- init_nodes  input  NUM_NODES*NUM_COLORS_BITS  initial packed colours
- new_val  input  1  sampled bit from node update datapath
- node_count  output  NUM_NODES_BIT  node currently updated
- color_bit_count  output  log2(NUM_COLORS_BITS)  colour bit currently updated
- nodes  output  NUM_NODES*NUM_COLORS_BITS  packed state; node i at [i*NUM_COLORS_BITS +: NUM_COLORS_BITS]
- busy  output  1  run in progress
- done  output  1  one-cycle completion pulse
- sweep_count  output  SWEEP_BITS  sweeps completed in current/last run

Behaviour:
- Reset (async, rst=0):
  - nodes, node_count, color_bit_count, busy, done, sweep_count, shadow colour, wait counter all 0.
  - State = IDLE.
- States: IDLE, BIT, COMMIT, FINISH.
- IDLE:
  - load_init=1 loads nodes<=init_nodes. If start is also 1, load takes effect first and the run uses the loaded value.
  - start=1 latches num_sweeps and clears sweep_count, node_count, color_bit_count, shadow.
  - If num_sweeps=0, go to FINISH; else go to BIT. busy=1 from the next cycle.
- BIT:
  - node_count/color_bit_count held stable for UPD_LATENCY+1 cycles.
  - new_val is sampled only in the last of those cycles into shadow[color_bit_count]; all other cycles ignore it.
  - If not the last bit: color_bit_count+1, stay in BIT. If last bit (NUM_COLORS_BITS-1): go to COMMIT.
- COMMIT (1 cycle):
  - Writes shadow into the node_count slot of nodes.
  - If shadow>=NUM_COLORS, writes NUM_COLORS-1 instead (clamp).
  - Clears shadow and color_bit_count.
  - If node_count<NUM_NODES-1: node_count+1, go to BIT.
  - Else node_count wraps to 0 and sweep_count+1. If sweep_count+1==latched num_sweeps, go to FINISH; else go to BIT.
- Bit-update semantics: within one node, all bits are computed against the old colour; nodes changes only in COMMIT.
- FINISH (1 cycle): done=1, busy=0, go to IDLE.
- Cycles from start edge to done, N=num_sweeps: N*NUM_NODES*(NUM_COLORS_BITS*(UPD_LATENCY+1)+1)+1.
- While busy:
  - start is ignored, load_init is ignored, num_sweeps changes are ignored.
- In IDLE: node_count and color_bit_count hold their last values (0 after a complete run); sweep_count holds the final value.
- sweep_count does not wrap within a run; num_sweeps max = 2^SWEEP_BITS-1.
- Reset mid-run: immediate return to reset values, and a partial shadow is discarded.

Optional Feature:
- Macro GIBBS_SWEEP_ABORT_EN.
- When defined, adds input `abort` (1 bit).
  - abort=1 while busy: in the next cycle the FSM goes to FINISH (done pulse, busy=0).
  - Any in-progress shadow bits are discarded; nodes keeps its last committed values.
  - sweep_count reports completed sweeps only.
  - abort in IDLE has no effect.
- When not defined: no abort port, and a run always completes.

Test Plan:
- Reset: rst=0 mid-idle -> nodes=0, busy=0, done=0, sweep_count=0; outputs stay 0 after release until start.
- Defaults, load_init with init_nodes=8'hE4, start num_sweeps=1, new_val tied 1 -> busy for 12 cycles, done pulse at cycle 13, nodes=8'hFF, sweep_count=1; node_count sequence 0,0,0,1,1,1,2,...
- NUM_COLORS=3, new_val tied 1, num_sweeps=2 -> every node clamps 3->2, nodes=8'hAA, 24 busy cycles, sweep_count=2.
- num_sweeps=0 with init 8'h1B -> done one cycle after start, nodes=8'h1B unchanged, busy never high; start asserted mid-run of another test -> ignored, run length unchanged.
- UPD_LATENCY=2, new_val=1 only in cycles 0-1 of each slot and 0 in the sample cycle -> all colours 0; node_count stable 3 cycles per bit, 7 cycles per node.
- Assert rst=0 at cycle 5 of a run -> all outputs 0 immediately; new start after release runs the full length. With GIBBS_SWEEP_ABORT_EN, abort at cycle 4 -> done next cycle, only node 0 committed.
